instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
//  Program writer for the MiniAlu instruction store: accepts a framed byte stream on a valid/ready port.
//  Assembles 28-bit instructions and writes them into the instruction RAM at consecutive addresses from 0.
//  Holds the ALU core in reset (oCpuReset) until a complete, checksum-valid image is written.
//  Sits between the host byte link and the RAM write port; the ALU fetch path is the read side.
// PARAMETERS
//  ADDR_W       16         instruction address width (oWriteAddress)
//  HEADER       8'hA5      frame start byte
//  TIMEOUT_CYC  1000000    max Clock cycles between accepted bytes inside a frame; 0 disables timeout
// PORTS
//  Clock          in   1       single clock, all logic on posedge
//  Reset          in   1       asynchronous, active-low reset
//  iByte          in   8       stream data byte
//  iByteValid     in   1       iByte valid
//  oByteReady     out  1       loader can accept; a transfer occurs when iByteValid & oByteReady
//  oWriteEnable   out  1       one-cycle RAM write strobe
//  oWriteAddress  out  ADDR_W  RAM write address
//  oInstruction   out  28      RAM write data
//  oCpuReset      out  1       active-high reset to ALU core
//  oDone          out  1       image loaded and verified
//  oError         out  1       last frame failed (checksum, count, or timeout)
// BEHAVIOUR
//  Reset (async assert, sync release): state IDLE, oCpuReset=1, oDone=0, oError=0, oWriteEnable=0,
//   oWriteAddress=0, oInstruction=0, oByteReady=0 while Reset low, 1 from the first cycle after release.
//  Frame: HEADER, N (1..255 instructions), N x 4 bytes big-endian (byte0[3:0]=instr[27:24], byte0[7:4] ignored),
//   CHK = XOR of N and all 4N data bytes.
//  States: IDLE -> COUNT -> DATA -> CHECK -> DONE | ERR.
//   IDLE: non-HEADER bytes are accepted and discarded; HEADER -> COUNT, clear checksum/addr/byte counter.
//   COUNT: N==0 or N > 2**ADDR_W -> ERR; else latch N -> DATA.
//   DATA: shift bytes into a 28-bit assembler; on the 4th byte, next cycle: oWriteEnable=1 for exactly 1 cycle.
//    oWriteAddress = instruction index (0..N-1), oInstruction = assembled word. Address increments after the write.
//    After the Nth write -> CHECK.
//   CHECK: next byte compared with running XOR; match -> DONE, mismatch -> ERR.
//   DONE: oDone=1, oCpuReset=0 (deasserted the cycle after entering DONE). A HEADER byte restarts the load:
//    oCpuReset=1 and oDone=0 in the cycle after the HEADER is accepted -> COUNT. Other bytes are ignored.
//   ERR: oError=1, oCpuReset=1. A HEADER byte clears oError -> COUNT. Other bytes are ignored.
//  oByteReady=1 in every state after reset; no back-pressure, because the write is a 1-cycle side effect.
//  Bytes at 1/cycle are supported: a write strobe and the next byte acceptance can occur in the same cycle.
//  Timeout: in COUNT/DATA/CHECK, if TIMEOUT_CYC cycles pass with no transfer -> ERR. The counter clears on every transfer.
//  Partial image on error: RAM words already written stay. The core remains in reset, so they are never executed.
//  Reset low mid-frame: immediate abort to IDLE. Any in-flight write strobe is dropped.
//  HEADER value inside DATA/CHECK is treated as data, not a restart.
// STRUCTURE
//  Shared definitions include (alongside the opcode defines): loader state encodings, HEADER default, frame field widths.
//  One sub-module: loader_timeout_counter (load/clear on transfer, terminal-count flag, disabled when TIMEOUT_CYC==0).
//  FSM, byte assembler, checksum and address counter stay in this module.
// TESTING
//  Load A5,02, 01 23 45 67, 0A BC DE F0, CHK=02^..^F0 ->
//   writes addr0=28'h1234567, addr1=28'hABCDEF0; oDone=1; oCpuReset falls.
//  Same frame with CHK bit-flipped -> both writes occur, oError=1, oDone=0, oCpuReset stays 1.
//  Bytes 00,FF before A5 in IDLE -> ignored; subsequent valid frame loads normally.
//  N=0 -> ERR immediately. With ADDR_W=2, N=5 -> ERR with no writes.
//  TIMEOUT_CYC=16, stall 16 cycles after the 2nd data byte -> ERR. The next A5 frame then loads, clearing oError.
//  Pull Reset low during DATA -> all outputs at reset values asynchronously.
//   After release, a second frame in DONE with new contents reasserts oCpuReset, then rewrites from addr 0.

Source files
------------

// File: rtl/instr_mem_loader_pkg.sv
// Shared definitions for the MiniAlu instruction loader: frame field widths,
// header default and loader state encodings.
package instr_mem_loader_pkg;

  localparam int unsigned BYTE_W          = 8;
  localparam int unsigned INSTR_W         = 28;
  localparam int unsigned BYTES_PER_INSTR = 4;
  localparam int unsigned COUNT_W         = 8;
  localparam int unsigned ASM_W           = INSTR_W - BYTE_W;

  localparam logic [BYTE_W-1:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_COUNT,
    ST_DATA,
    ST_CHECK,
    ST_DONE,
    ST_ERR
  } loaderState_t;

  // The assembler keeps only the low 20 bits of the partial word, so byte0[7:4] falls off naturally.
  function automatic logic [INSTR_W-1:0] packInstr(input logic [ASM_W-1:0]  partial,
                                                   input logic [BYTE_W-1:0] nextByte);
    return {partial, nextByte};
  endfunction

endpackage

// File: rtl/instr_mem_loader_timeout_counter.sv
// Inter-byte timeout for the instruction loader: counts idle cycles while enabled,
// clears on every transfer, flags expiry; never expires when TIMEOUT_CYC is 0.
module loader_timeout_counter #(
  parameter int unsigned TIMEOUT_CYC = 1000000
) (
  input  logic Clock,
  input  logic Reset,
  input  logic enable,
  input  logic clear,
  output logic expired
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] TERMINAL = CNT_W'((TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1);
  localparam logic TIMEOUT_ON = (TIMEOUT_CYC != 0);

  logic [CNT_W-1:0] idleCount;

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      idleCount <= '0;
    end else if (!enable || clear) begin
      idleCount <= '0;
    end else if (idleCount != TERMINAL) begin
      idleCount <= idleCount + CNT_W'(1);
    end
  end

  // Expires on the edge that ends the TIMEOUT_CYC-th consecutive idle cycle.
  always_comb begin
    expired = TIMEOUT_ON && enable && !clear && (idleCount == TERMINAL);
  end

endmodule

// File: rtl/instr_mem_loader.sv
// MiniAlu program writer: parses framed byte stream, writes 28-bit instructions
// from address 0 and releases the core reset only after a checksum-valid image.
module instr_mem_loader
  import instr_mem_loader_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 16,
  parameter logic [BYTE_W-1:0] HEADER      = HEADER_DEFAULT,
  parameter int unsigned       TIMEOUT_CYC = 1000000
) (
  input  logic               Clock,
  input  logic               Reset,
  input  logic [7:0]         iByte,
  input  logic               iByteValid,
  output logic               oByteReady,
  output logic               oWriteEnable,
  output logic [ADDR_W-1:0]  oWriteAddress,
  output logic [27:0]        oInstruction,
  output logic               oCpuReset,
  output logic               oDone,
  output logic               oError
);

  localparam longint unsigned MAX_N = 64'd1 << ADDR_W;

  loaderState_t        state, stateNext;
  logic                xfer;
  logic                isHeader;
  logic                countBad;
  logic                lastByteOfWord;
  logic                timedOut;
  logic                timerEnable;
  logic [BYTE_W-1:0]   checksum;
  logic [ASM_W-1:0]    assembler;
  logic [INSTR_W-1:0]  nextWord;
  logic [1:0]          byteCnt;
  logic [COUNT_W-1:0]  instrLeft;
  logic [ADDR_W-1:0]   instrIdx;

  always_comb begin
    xfer           = iByteValid && oByteReady;
    isHeader       = (iByte == HEADER);
    countBad       = (iByte == '0) || (64'(iByte) > MAX_N);
    lastByteOfWord = (byteCnt == 2'(BYTES_PER_INSTR - 1));
    nextWord       = packInstr(assembler, iByte);
    timerEnable    = (state == ST_COUNT) || (state == ST_DATA) || (state == ST_CHECK);
  end

  loader_timeout_counter #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) uTimeout (
    .Clock  (Clock),
    .Reset  (Reset),
    .enable (timerEnable),
    .clear  (xfer),
    .expired(timedOut)
  );

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  always_comb begin
    stateNext = state;
    oDone     = 1'b0;
    oError    = 1'b0;
    oCpuReset = 1'b1;
    case (state)
      ST_IDLE: begin
        if (xfer && isHeader) stateNext = ST_COUNT;
      end
      ST_COUNT: begin
        if (xfer) stateNext = countBad ? ST_ERR : ST_DATA;
      end
      ST_DATA: begin
        if (xfer && lastByteOfWord && (instrLeft == COUNT_W'(1))) stateNext = ST_CHECK;
      end
      ST_CHECK: begin
        if (xfer) stateNext = (iByte == checksum) ? ST_DONE : ST_ERR;
      end
      ST_DONE: begin
        oDone     = 1'b1;
        oCpuReset = 1'b0;
        if (xfer && isHeader) stateNext = ST_COUNT;
      end
      ST_ERR: begin
        oError = 1'b1;
        if (xfer && isHeader) stateNext = ST_COUNT;
      end
      default: stateNext = ST_IDLE;
    endcase
    if (timedOut) stateNext = ST_ERR;
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      oByteReady    <= 1'b0;
      oWriteEnable  <= 1'b0;
      oWriteAddress <= '0;
      oInstruction  <= '0;
      checksum      <= '0;
      assembler     <= '0;
      byteCnt       <= '0;
      instrLeft     <= '0;
      instrIdx      <= '0;
    end else begin
      oByteReady   <= 1'b1;
      oWriteEnable <= 1'b0;
      if (xfer) begin
        case (state)
          ST_IDLE, ST_DONE, ST_ERR: begin
            if (isHeader) begin
              checksum <= '0;
              byteCnt  <= '0;
              instrIdx <= '0;
            end
          end
          ST_COUNT: begin
            checksum  <= iByte;
            instrLeft <= iByte;
          end
          ST_DATA: begin
            checksum  <= checksum ^ iByte;
            assembler <= nextWord[ASM_W-1:0];
            byteCnt   <= byteCnt + 2'd1;
            // The write is registered, so it lands while the next byte is already being accepted.
            if (lastByteOfWord) begin
              oWriteEnable  <= 1'b1;
              oWriteAddress <= instrIdx;
              oInstruction  <= nextWord;
              instrIdx      <= instrIdx + ADDR_W'(1);
              instrLeft     <= instrLeft - COUNT_W'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
